psum_collector: RTL and testbench
=================================

# psum_collector

South-edge output collector for the reconfigurable MAC array. It captures the skewed per-column `out_s` streams leaving the bottom row: WS partial sums in WS mode, and flushed `c_q` accumulators in OS flush. Each column has its own FIFO. When every column holds at least one entry, the block presents a de-skewed, row-aligned word to the downstream SFU/memory writer. A run FSM counts the rows drained and flags completion.

## Interface
Parameters:
- `col`, default 8: number of array columns.
- `psum_bw`, default 16: width of one column's partial sum.
- `depth`, default 16: entries per column FIFO; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high.
- `in_data`  in  `col*psum_bw`  bottom-row `out_s` values; column i occupies bits `[i*psum_bw +: psum_bw]`.
- `in_valid`  in  `col`  per-column write strobe; the skew between columns is arbitrary.
- `start`  in  1  one-cycle pulse that arms a run.
- `rows_expected`  in  8  number of rows in the run; sampled on `start`.
- `rd_en`  in  1  downstream pop request.
- `out_data`  out  `col*psum_bw`  registered row word; same column packing as `in_data`.
- `out_valid`  out  1  one-cycle pulse: `out_data` was updated this cycle.
- `row_ready`  out  1  every column FIFO is non-empty.
- `o_full`  out  1  at least one column FIFO is full.
- `o_empty`  out  1  every column FIFO is empty.
- `overflow`  out  1  sticky: a write was dropped.
- `done`  out  1  the run has completed.

## Operation
- **Column FIFOs.** Each column uses wr_ptr and rd_ptr of width `log2(depth)+1`.
  - empty: the pointers are equal.
  - full: the MSBs differ and the low bits are equal.
  - Pointers wrap naturally modulo `2*depth`.
- **Write rule.** If `in_valid[i]` is high and column i is not full at the start of the cycle, `in_data` slice i is pushed.
  - If column i is full, the write is dropped and `overflow` is set.
  - A pop of column i in the same cycle does not unblock the write; fullness is evaluated before the pop.
- **Read rule.** A pop happens when `rd_en` is high and `row_ready` is high. All columns pop together.
  - `out_data` latches the head entry of every column.
  - `out_valid` pulses high in the next cycle.
  - `rd_en` while `row_ready` is low: no pop, no `out_valid`, `out_data` holds its value.
- **Simultaneous push and pop on a non-full, non-empty column.** Both take effect and the occupancy is unchanged.
- **Push and pop on an empty column in the same cycle.** No pop occurs, because `row_ready` was low. The push lands.
- **Run FSM, states IDLE, RUN, DONE.**
  - IDLE → RUN on `start`. This loads `rows_expected` and clears row_cnt.
  - RUN: each pop increments row_cnt (8-bit). When a pop makes row_cnt equal `rows_expected`, the FSM goes to DONE.
  - `start` with `rows_expected = 0` goes directly to DONE on the next cycle.
  - DONE: `done` is high. `start` → RUN with a fresh count.
  - `start` during RUN restarts: the count is cleared and the target reloaded. FIFO contents are kept.
  - Pops in IDLE or DONE are still serviced but are not counted.
- **`overflow`** is cleared only by `reset` or `start`.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `row_ready` = 0, `o_full` = 0, `o_empty` = 1, `overflow` = 0, `done` = 0. FSM is in IDLE, all pointers are 0.
- Reset has priority over every other input. Asserting it mid-run discards FIFO contents and the count within one cycle.
- Write-to-visible latency: data pushed at edge t contributes to `row_ready` in the cycle after t. It is poppable at edge t+1 at the earliest.
- Pop latency: `rd_en` is sampled at edge t; `out_data` and `out_valid` are valid after edge t+1, i.e. 1 cycle.
- `row_ready`, `o_full` and `o_empty` are combinational from the pointers.
- `done` asserts in the cycle after the final counted pop, together with that pop's `out_valid`.
- Sustained throughput: one row per cycle when `rd_en` is held high and the columns keep pace.

## Test plan
- **Aligned fill and drain.** `col`=8, `depth`=16. Write rows r=0..3 with all `in_valid` high and column i = 16·r+i. Then hold `rd_en` for 4 cycles. Required: 4 `out_valid` pulses, row r column i = 16·r+i, then `o_empty`=1 and `row_ready`=0.
- **Skewed input.** Column i writes value 100+i at cycle 10+i. Required: `row_ready` rises only after column 7's write (cycle 18). A `rd_en` asserted from cycle 10 yields exactly one `out_valid`, at cycle 19, carrying 100..107 in order.
- **Full and overflow.** Write 17 entries to column 0 only. Required: `o_full`=1 after the 16th. The 17th is dropped with `overflow`=1, and the drained column 0 holds values 0..15 only.
- **Run count.** `start` with `rows_expected`=3, then 5 rows written and `rd_en` held. Required: `done` rises with the 3rd `out_valid`. The 4th and 5th pops still pulse `out_valid`, and `done` stays 1.
- **Reset mid-run.** Assert `reset` after 2 of 4 expected rows have popped. Required: next cycle all outputs are at reset values and a subsequent row pop requires fresh writes.
- **Boundary.** `start` with `rows_expected`=0 → `done` the next cycle. Push and pop on a column holding 1 entry in the same cycle → occupancy stays 1.

Source files
------------

// File: rtl/psum_collector_if.sv
// Row-stream bundle between the MAC array south edge, the collector and the downstream writer.
// The collector takes the slave side; the driving environment takes the master side.
interface psum_collector_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0] in_data;
  logic [col-1:0]         in_valid;
  logic                   rd_en;
  logic [col*psum_bw-1:0] out_data;
  logic                   out_valid;
  logic                   row_ready;

  modport master (
    output in_data, in_valid, rd_en,
    input  out_data, out_valid, row_ready
  );

  modport slave (
    input  in_data, in_valid, rd_en,
    output out_data, out_valid, row_ready
  );
endinterface

// File: rtl/psum_collector.sv
// South-edge collector: per-column FIFOs absorb skewed out_s streams and
// release de-skewed row words; a run FSM counts the drained rows.
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                clk,
  input  logic                reset,
  psum_collector_if.slave     bus,
  input  logic                start,
  input  logic [7:0]          rows_expected,
  output logic                o_full,
  output logic                o_empty,
  output logic                overflow,
  output logic                done
);
  localparam int AW = $clog2(depth);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [col-1:0]         full, empty;
  logic [col*psum_bw-1:0] head;
  logic                   pop;
  logic                   count_en;
  logic [7:0]             row_cnt, target;

  assign bus.row_ready = ~|empty;
  assign o_full        = |full;
  assign o_empty       = &empty;
  assign pop           = bus.rd_en & bus.row_ready;

  for (genvar i = 0; i < col; i++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               push;

    assign empty[i] = (wr_ptr == rd_ptr);
    assign full[i]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // fullness is taken from the start-of-cycle pointers, so a same-cycle pop never admits a write
    assign push     = bus.in_valid[i] & ~full[i];
    assign head[i*psum_bw +: psum_bw] = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data[i*psum_bw +: psum_bw];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      bus.out_valid <= pop;
      if (pop) bus.out_data <= head;
      overflow <= (start ? 1'b0 : overflow) | (|(bus.in_valid & full));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      target  <= '0;
    end else if (start) begin
      row_cnt <= '0;
      target  <= rows_expected;
    end else if (count_en && pop) begin
      row_cnt <= row_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (rows_expected == '0) ? DONE : RUN;
    end else if (state_q == RUN && pop && (row_cnt + 8'd1 == target)) begin
      state_d = DONE;
    end
  end

  always_comb begin
    done     = (state_q == DONE);
    count_en = (state_q == RUN);
  end
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: expected rows go into a queue at stimulus
// time and an independent negedge monitor checks every out_valid against it.
module tb_psum_collector;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int W   = COL*BW;

  typedef struct {
    logic [W-1:0] data;
    logic         done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rows_expected;
  logic       o_full, o_empty, overflow, done;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e;

  psum_collector_if #(.col(COL), .psum_bw(BW)) bus ();

  psum_collector #(.col(COL), .psum_bw(BW), .depth(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .start         (start),
    .rows_expected (rows_expected),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mkrow(input int base, input int stride);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(base + stride*i);
    return r;
  endfunction

  task automatic expect_row(input logic [W-1:0] d, input logic dn);
    exp_t x;
    x.data = d;
    x.done = dn;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_data %0h with no row expected", bus.out_data);
      end else begin
        e = q.pop_front();
        chk("row_data", bus.out_data, e.data);
        chk("row_done", done, e.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; rows_expected = '0;
    bus.in_data = '0; bus.in_valid = '0; bus.rd_en = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_out_data",  bus.out_data,  '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_row_ready", bus.row_ready, 1'b0);
    chk("rst_o_full",    o_full,        1'b0);
    chk("rst_o_empty",   o_empty,       1'b1);
    chk("rst_overflow",  overflow,      1'b0);
    chk("rst_done",      done,          1'b0);
    reset = 1'b0;
    step();

    // aligned fill and drain
    for (int r = 0; r < 4; r++) begin
      bus.in_valid = '1; bus.in_data = mkrow(16*r, 1);
      step();
    end
    bus.in_valid = '0;
    for (int r = 0; r < 4; r++) begin
      expect_row(mkrow(16*r, 1), 1'b0);
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("aligned_o_empty",   o_empty,       1'b1);
    chk("aligned_row_ready", bus.row_ready, 1'b0);
    step();

    // skewed input with rd_en held throughout
    bus.rd_en = 1'b1;
    for (int c = 0; c < COL; c++) begin
      bus.in_valid = '0; bus.in_valid[c] = 1'b1; bus.in_data = mkrow(100, 1);
      @(negedge clk);
      chk("skew_row_ready_low", bus.row_ready, 1'b0);
      step();
    end
    bus.in_valid = '0;
    @(negedge clk);
    chk("skew_row_ready_high", bus.row_ready, 1'b1);
    expect_row(mkrow(100, 1), 1'b0);
    step(); step(); step();
    @(negedge clk);
    chk("skew_out_data_hold", bus.out_data, mkrow(100, 1));
    bus.rd_en = 1'b0;
    step();

    // full and overflow on column 0
    for (int k = 0; k < 17; k++) begin
      bus.in_valid = 8'h01; bus.in_data = mkrow(k, 0);
      step();
      if (k == 15) begin
        @(negedge clk);
        chk("full_after_16",    o_full,   1'b1);
        chk("no_overflow_yet",  overflow, 1'b0);
      end
    end
    bus.in_valid = '0;
    @(negedge clk);
    chk("overflow_set", overflow, 1'b1);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 8'hFE; bus.in_data = mkrow(k, 0);
      step();
    end
    bus.in_valid = '0;
    for (int k = 0; k < 16; k++) begin
      expect_row(mkrow(k, 0), 1'b0);
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("drain_o_empty",   o_empty,  1'b1);
    chk("overflow_sticky", overflow, 1'b1);
    step();

    // run count of 3 with 5 rows drained
    start = 1'b1; rows_expected = 8'd3;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("start_clears_overflow", overflow, 1'b0);
    chk("run_done_low",          done,     1'b0);
    for (int r = 0; r < 5; r++) begin
      bus.in_valid = '1; bus.in_data = mkrow('h300 + 16*r, 1);
      step();
    end
    bus.in_valid = '0;
    for (int r = 0; r < 5; r++) begin
      expect_row(mkrow('h300 + 16*r, 1), (r >= 2));
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("run_done_stays", done, 1'b1);
    step();

    // reset after 2 of 4 rows
    start = 1'b1; rows_expected = 8'd4;
    step();
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.in_valid = '1; bus.in_data = mkrow('h400 + 16*r, 1);
      step();
    end
    bus.in_valid = '0;
    for (int r = 0; r < 2; r++) begin
      expect_row(mkrow('h400 + 16*r, 1), 1'b0);
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_data",  bus.out_data,  '0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_row_ready", bus.row_ready, 1'b0);
    chk("mid_rst_o_empty",   o_empty,       1'b1);
    chk("mid_rst_done",      done,          1'b0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    bus.in_valid = '1; bus.in_data = mkrow('h480, 1);
    step();
    bus.in_valid = '0;
    expect_row(mkrow('h480, 1), 1'b0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    step();

    // rows_expected = 0, then same-cycle push/pop on single-entry columns
    start = 1'b1; rows_expected = 8'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("zero_rows_done", done, 1'b1);
    bus.in_valid = '1; bus.in_data = mkrow('h500, 1);
    step();
    bus.in_data = mkrow('h600, 1); bus.rd_en = 1'b1;
    expect_row(mkrow('h500, 1), 1'b1);
    step();
    bus.in_valid = '0; bus.rd_en = 1'b0;
    @(negedge clk);
    chk("pushpop_row_ready", bus.row_ready, 1'b1);
    chk("pushpop_o_empty",   o_empty,       1'b0);
    expect_row(mkrow('h600, 1), 1'b1);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("pushpop_occupancy_one", o_empty, 1'b1);
    step(); step();

    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
